// File: rtl/sa_pkg.sv
// Shared constants, state encoding and skewed-address helper for the
// operand skew loader and its address generator.
package sa_pkg;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned PAD      = 7;
  localparam int unsigned ROW_BITS = $clog2(ROWS);
  localparam int unsigned ADDR_W   = ROW_BITS + COL_W;
  // Wide enough for the CLEAR column index, which reaches N+6 = 21.
  localparam int unsigned IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    FIN
  } state_t;

  // Bank in the top bits and the column wrapped inside the bank.
  // With skew set, row r is pushed right by r columns.
  function automatic logic [ADDR_W-1:0] skew_addr(
    input logic [ROW_BITS-1:0] r,
    input logic [IDX_W-1:0]    k,
    input logic [COL_W-1:0]    base,
    input logic                skew
  );
    logic [COL_W-1:0] col;
    col = base + COL_W'(k) + (skew ? COL_W'(r) : '0);
    return {r, col};
  endfunction

endpackage

// File: rtl/operand_skew_loader_if.sv
// Control, element-stream and memory write-port signals of one operand loader.
interface operand_skew_loader_if;
  import sa_pkg::*;

  logic              start;
  logic [3:0]        n_len;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_en;
  logic [COL_W-1:0]  base_col;

  // Tile source and memory observer side.
  modport master (
    output start, n_len, s_valid, s_data,
    input  busy, done, s_ready, mem_addr, mem_data, mem_en, base_col
  );

  // Loader side.
  modport slave (
    input  start, n_len, s_valid, s_data,
    output busy, done, s_ready, mem_addr, mem_data, mem_en, base_col
  );

endinterface

// File: rtl/skew_addr_gen.sv
// Row/column counter pair with wrap-add onto the tile base column.
// CLEAR walks c = 0..N+6 unskewed; LOAD walks k = 0..N-1 skewed by row.
module skew_addr_gen
  import sa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic                skew,
  input  logic [IDX_W-1:0]    last_c,
  input  logic [COL_W-1:0]    base,
  output logic [ADDR_W-1:0]   addr,
  output logic                last
);

  logic [ROW_BITS-1:0] r_q;
  logic [IDX_W-1:0]    c_q;

  // Column is the inner loop; it wraps into the next row at last_c.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
      c_q <= '0;
    end else if (inc) begin
      if (c_q == last_c) begin
        c_q <= '0;
        r_q <= r_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  // Current word address and end-of-walk flag.
  always_comb begin
    addr = skew_addr(r_q, c_q, base, skew);
    last = (r_q == ROW_BITS'(ROWS - 1)) && (c_q == last_c);
  end

endmodule

// File: rtl/operand_skew_loader.sv
// Writer-side front end for one 4-row operand memory: zero-fills the tile
// footprint, then writes the streamed tile pre-skewed so row r lags r columns.
module operand_skew_loader
  import sa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  operand_skew_loader_if.slave bus
);

  state_t            state_q, state_d;
  logic [3:0]        n_q, n_d;
  logic [COL_W-1:0]  base_q, base_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;

  logic              gen_clr, gen_inc, gen_skew, gen_last;
  logic [IDX_W-1:0]  gen_last_c;
  logic [ADDR_W-1:0] gen_addr;
  logic              hs;

  assign hs = bus.s_valid & s_ready_q;

  skew_addr_gen u_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (gen_clr),
    .inc    (gen_inc),
    .skew   (gen_skew),
    .last_c (gen_last_c),
    .base   (base_q),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  // State and registered outputs; reset aborts any tile and rewinds the base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      base_q     <= base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s_ready_q  <= s_ready_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Next state, next output values and address-generator control.
  // Outputs are computed one cycle early so every port comes from a flop.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    base_d     = base_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    s_ready_d  = s_ready_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    gen_clr    = 1'b0;
    gen_inc    = 1'b0;
    gen_skew   = 1'b0;
    gen_last_c = IDX_W'(n_q) + IDX_W'(PAD - 1);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.n_len == '0) begin
            done_d = 1'b1;
          end else begin
            n_d     = bus.n_len;
            busy_d  = 1'b1;
            gen_clr = 1'b1;
            state_d = CLEAR;
          end
        end
      end

      CLEAR: begin
        mem_en_d   = 1'b1;
        mem_addr_d = gen_addr;
        mem_data_d = '0;
        gen_inc    = 1'b1;
        if (gen_last) begin
          gen_clr   = 1'b1;
          s_ready_d = 1'b1;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        gen_skew   = 1'b1;
        gen_last_c = IDX_W'(n_q) - 1'b1;
        if (hs) begin
          mem_en_d   = 1'b1;
          mem_addr_d = gen_addr;
          mem_data_d = bus.s_data;
          gen_inc    = 1'b1;
          if (gen_last) begin
            s_ready_d = 1'b0;
            state_d   = FIN;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        base_d  = base_q + COL_W'(n_q) + COL_W'(PAD);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.s_ready  = s_ready_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.base_col = base_q;

endmodule

// File: tb/tb_operand_skew_loader.sv
// Directed bench for operand_skew_loader: every expected memory write is
// queued when its cause is driven and matched against the write port.
module tb_operand_skew_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
    logic        clr;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  operand_skew_loader_if bus ();

  operand_skew_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          clear_left = 0;
  int unsigned model_base = 0;
  wr_t         sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor and s_ready phase check.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_en === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0d data %0h expected no write",
               bus.mem_addr, bus.mem_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write", {38'd0, bus.mem_addr, bus.mem_data}, {38'd0, e.addr, e.data});
        if (e.clr) clear_left--;
      end
    end
    if (bus.s_ready === 1'b1)
      chk("s_ready_only_in_load", {62'd0, bus.busy, (clear_left == 0)}, 64'd3);
  end

  task automatic chk_all_zero(input string tag);
    chk(tag, {26'd0, bus.busy, bus.done, bus.s_ready, bus.mem_en,
              bus.mem_addr, bus.mem_data, bus.base_col}, 64'd0);
  endtask

  // One tile: start, expected clear image, stream, completion checks.
  task automatic run_tile(input int unsigned n, input int unsigned gap_pct,
                          input bit seq, input bit inject_start, input int abort_at);
    logic [15:0] dat [60];
    int unsigned idx;
    int unsigned cyc;
    int unsigned r;
    int unsigned k;
    bit          v;
    wr_t         e;
    for (int i = 0; i < 60; i++) dat[i] = seq ? 16'(i + 1) : 16'($urandom);

    @(negedge clk);
    bus.start = 1'b1;
    bus.n_len = 4'(n);
    if (n > 0) begin
      for (int unsigned rr = 0; rr < 4; rr++)
        for (int unsigned c = 0; c < n + 7; c++) begin
          e.addr = 10'(rr * 256 + ((model_base + c) % 256));
          e.data = '0;
          e.clr  = 1'b1;
          sb.push_back(e);
        end
      clear_left += int'(4 * (n + 7));
    end
    @(negedge clk);
    bus.start = 1'b0;

    if (n == 0) begin
      chk("n0_done_next_cycle", {63'd0, bus.done}, 64'd1);
      chk("n0_not_busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      chk("n0_done_pulse", {63'd0, bus.done}, 64'd0);
      chk("n0_base_unchanged", {56'd0, bus.base_col}, 64'(model_base));
      return;
    end

    chk("busy_rise", {63'd0, bus.busy}, 64'd1);

    if (inject_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.n_len = 4'd9;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_during_clear", {63'd0, bus.busy}, 64'd1);
    end

    idx = 0;
    cyc = 0;
    while (idx < 4 * n && cyc < 4000) begin
      if (abort_at >= 0 && int'(idx) == abort_at) break;
      v = ($urandom_range(99) >= gap_pct);
      bus.s_valid = v;
      bus.s_data  = dat[idx];
      if (v && bus.s_ready === 1'b1) begin
        r = idx / n;
        k = idx % n;
        e.addr = 10'(r * 256 + ((model_base + r + k) % 256));
        e.data = dat[idx];
        e.clr  = 1'b0;
        sb.push_back(e);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;

    if (abort_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      chk("abort_no_pending_writes", 64'(sb.size()), 64'd0);
      chk_all_zero("abort_reset_outputs");
      sb.delete();
      clear_left = 0;
      model_base = 0;
      rst = 1'b0;
      return;
    end

    chk("all_elements_accepted", 64'(idx), 64'(4 * n));
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {63'd0, bus.done}, 64'd1);
    model_base = (model_base + n + 7) % 256;
    chk("base_col", {56'd0, bus.base_col}, 64'(model_base));
    chk("busy_low_at_done", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk("done_pulse", {63'd0, bus.done}, 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.n_len   = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    run_tile(2, 0, 1'b1, 1'b0, -1);
    run_tile(1, 0, 1'b1, 1'b0, -1);
    run_tile(0, 0, 1'b1, 1'b0, -1);
    run_tile(2, 50, 1'b1, 1'b0, -1);
    for (int t = 0; t < 9; t++) run_tile(15, 50, 1'b0, 1'b0, -1);
    run_tile(6, 50, 1'b0, 1'b0, -1);
    run_tile(6, 50, 1'b0, 1'b0, -1);
    chk("base_before_wrap", {56'd0, bus.base_col}, 64'd250);
    run_tile(4, 0, 1'b0, 1'b0, -1);
    run_tile(3, 0, 1'b0, 1'b1, 5);
    run_tile(2, 0, 1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
